// File: rtl/btn_pkg.sv
// Shared constants for the button event FSM: state encoding and the press-counter width.
package btn_pkg;

  localparam int COUNT_W = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd1;
  localparam logic [1:0] ST_LONG    = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    PRESSED = ST_PRESSED,
    LONG    = ST_LONG
  } btn_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Registers the previous debounced level and flags its rising and falling edges.
module edge_detect (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iS,
  output logic oRise,
  output logic oFall
);

  logic prev_q;

  // previous-level register; clears to 0 so a level held through reset reads as a press
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= iS;
    end
  end

  assign oRise = iS & ~prev_q;
  assign oFall = ~iS & prev_q;

endmodule

// File: rtl/button_event_fsm.sv
// Turns a debounced button level into press/release/long/repeat pulses, a held flag and a press count.
// Auto-repeat is built only when BTN_AUTOREPEAT_EN is defined; otherwise oRepeat is tied low.
module button_event_fsm
  import btn_pkg::*;
#(
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int CNT_W         = 26
) (
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic               iS,
  output logic               oPress,
  output logic               oRelease,
  output logic               oLong,
  output logic               oRepeat,
  output logic               oHeld,
  output logic [COUNT_W-1:0] oCount
);

  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 1 ||
      longint'(max_int(HOLD_CYCLES, REPEAT_CYCLES)) >= (longint'(1) << CNT_W)) begin : g_param_check
    $error("button_event_fsm: illegal HOLD_CYCLES/REPEAT_CYCLES/CNT_W combination");
  end

  logic rise_s;
  logic fall_s;

  edge_detect u_edge_detect (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iS     (iS),
    .oRise  (rise_s),
    .oFall  (fall_s)
  );

  btn_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COUNT_W-1:0] presses_q, presses_d;
  logic               press_q, press_d;
  logic               release_q, release_d;
  logic               long_q, long_d;
  logic               held_q, held_d;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_C = CNT_W'(REPEAT_CYCLES);
  logic repeat_q, repeat_d;
`endif

  // next-state, hold/repeat counter and event pulses
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    presses_d = presses_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    repeat_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (rise_s) begin
          press_d   = 1'b1;
          presses_d = presses_q + COUNT_W'(1);
          cnt_d     = ONE_C;
          state_d   = PRESSED;
        end else begin
          cnt_d = '0;
        end
      end
      PRESSED: begin
        // release takes priority over a threshold reached on the same edge
        if (fall_s) begin
          release_d = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else if (cnt_q == HOLD_C) begin
          long_d  = 1'b1;
          cnt_d   = ONE_C;
          state_d = LONG;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      LONG: begin
        if (fall_s) begin
          release_d = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
`ifdef BTN_AUTOREPEAT_EN
          if (cnt_q == REPEAT_C) begin
            repeat_d = 1'b1;
            cnt_d    = ONE_C;
          end else begin
            cnt_d = cnt_q + ONE_C;
          end
`else
          cnt_d = cnt_q;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    held_d = (state_d != IDLE);
  end

  // state, counter and registered outputs
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      presses_q <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      presses_q <= presses_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      held_q    <= held_d;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  // auto-repeat pulse register
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      repeat_q <= 1'b0;
    end else begin
      repeat_q <= repeat_d;
    end
  end

  assign oRepeat = repeat_q;
`else
  assign oRepeat = 1'b0;
`endif

  assign oPress   = press_q;
  assign oRelease = release_q;
  assign oLong    = long_q;
  assign oHeld    = held_q;
  assign oCount   = presses_q;

endmodule

// File: tb/tb_button_event_fsm.sv
// Self-checking bench for button_event_fsm: directed scenarios plus random level bursts,
// compared against a time-since-press reference model.
module tb_button_event_fsm;

  localparam int H = 8;
  localparam int R = 4;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s;
  logic       o_press, o_release, o_long, o_repeat, o_held;
  logic [7:0] o_count;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  bit m_prev, m_held;
  int m_t, m_cnt;
  bit e_press, e_rel, e_long, e_rep;

  button_event_fsm #(
    .HOLD_CYCLES   (H),
    .REPEAT_CYCLES (R),
    .CNT_W         (26)
  ) dut (
    .iClk     (clk),
    .iRst_n   (rst_n),
    .iS       (s),
    .oPress   (o_press),
    .oRelease (o_release),
    .oLong    (o_long),
    .oRepeat  (o_repeat),
    .oHeld    (o_held),
    .oCount   (o_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = 1'b0; m_held = 1'b0; m_t = 0; m_cnt = 0;
    e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0; e_rep = 1'b0;
  endtask

  // one clock edge of the model: t counts edges since the press edge
  task automatic model_edge(input bit si);
    e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0; e_rep = 1'b0;
    if (!m_held) begin
      if (si && !m_prev) begin
        e_press = 1'b1; m_held = 1'b1; m_t = 0; m_cnt = (m_cnt + 1) % 256;
      end
    end else begin
      m_t++;
      if (!si) begin
        e_rel = 1'b1; m_held = 1'b0;
      end else if (m_t == H) begin
        e_long = 1'b1;
      end else if (AR && m_t > H && ((m_t - H) % R) == 0) begin
        e_rep = 1'b1;
      end
    end
    m_prev = si;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".press"},   int'(o_press),   int'(e_press));
    chk({tag, ".release"}, int'(o_release), int'(e_rel));
    chk({tag, ".long"},    int'(o_long),    int'(e_long));
    chk({tag, ".repeat"},  int'(o_repeat),  int'(e_rep));
    chk({tag, ".held"},    int'(o_held),    int'(m_held));
    chk({tag, ".count"},   int'(o_count),   m_cnt);
    chk({tag, ".onehot"},  int'($countones({o_press, o_release, o_long, o_repeat}) <= 1), 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".press"},   int'(o_press),   0);
    chk({tag, ".release"}, int'(o_release), 0);
    chk({tag, ".long"},    int'(o_long),    0);
    chk({tag, ".repeat"},  int'(o_repeat),  0);
    chk({tag, ".held"},    int'(o_held),    0);
    chk({tag, ".count"},   int'(o_count),   0);
  endtask

  task automatic step(input logic si, input string tag);
    @(negedge clk);
    s = si;
    @(posedge clk);
    model_edge(si);
    #1;
    check_all(tag);
  endtask

  int long_seen, rep_seen, base_cnt;
  logic lvl;

  initial begin
    rst_n = 1'b0;
    s     = 1'b0;
    model_reset();
    #12;
    check_zero("reset");
    #1 rst_n = 1'b1;

    // 1: short press of 3 cycles
    for (int i = 0; i < 3; i++) step(1'b1, "t1_hold");
    step(1'b0, "t1_release");
    chk("t1_count_is_1", int'(o_count), 1);
    step(1'b0, "t1_idle");

    // 2/3: hold for 20 cycles; long at E+8, repeats only with auto-repeat
    long_seen = 0; rep_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, "t2_hold");
      if (o_long)   long_seen++;
      if (o_repeat) rep_seen++;
    end
    step(1'b0, "t2_release");
    chk("t2_long_once", long_seen, 1);
    chk("t2_repeat_count", rep_seen, AR ? 2 : 0);
    step(1'b0, "t2_idle");

    // 4: release exactly on the long threshold edge
    long_seen = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, "t4_hold");
      if (o_long) long_seen++;
    end
    step(1'b0, "t4_release");
    chk("t4_release_wins", int'(o_release), 1);
    chk("t4_no_long", long_seen + int'(o_long), 0);
    step(1'b0, "t4_idle");
    chk("t4_idle_held", int'(o_held), 0);

    // 5: 256 short presses wrap the counter back to its start value
    base_cnt = int'(o_count);
    for (int i = 0; i < 256; i++) begin
      step(1'b1, "t5_press");
      step(1'b0, "t5_release");
    end
    chk("t5_wrap", int'(o_count), base_cnt);
    step(1'b1, "t5_press257");
    chk("t5_after_wrap", int'(o_count), (base_cnt + 1) % 256);
    step(1'b0, "t5_release257");

    // 6: asynchronous reset mid-hold with the button kept pressed
    for (int i = 0; i < 5; i++) step(1'b1, "t6_hold");
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check_zero("t6_async_clear");
    #1 rst_n = 1'b1;
    step(1'b1, "t6_repress");
    chk("t6_press_after_reset", int'(o_press), 1);
    chk("t6_count_is_1", int'(o_count), 1);
    step(1'b0, "t6_release");

    // random bursts of alternating level
    lvl = 1'b0;
    for (int b = 0; b < 60; b++) begin
      int len;
      lvl = ~lvl;
      len = int'($urandom_range(1, 24));
      for (int j = 0; j < len; j++) step(lvl, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
